sdram_rd_sched: RTL and testbench
=================================

SDRAM_RD_SCHED -- requirements
Module: sdram_rd_sched

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- GUARD, 2, idle cycles required on the SDRAM read port before the motion-detect (MD) requester may read.
- LEN_W, 8, width of the MD burst-length field.
REQ-002 Ports, one per line (name, direction, width, meaning):
- iCLK, in, 1, LCD display clock; the only clock.
- iRST_n, in, 1, system reset, asynchronous, active-low.
- iLCD_REQ, in, 1, LCD pixel read enable from the LCD timing controller.
- iLCD_VD, in, 1, LCD vertical sync, active-low.
- iMD_REQ, in, 1, MD burst request (level).
- iMD_LEN, in, LEN_W, MD burst length in 16-bit words.
- iSWAP_REQ, in, 1, one-cycle request to swap the frame-buffer bank.
- oRD_EN, out, 1, read strobe to the shared SDRAM read FIFO.
- oRD_SEL, out, 1, read owner: 0 = LCD, 1 = MD.
- oMD_GNT, out, 1, high while MD owns a burst.
- oMD_VALID, out, 1, a word is read for MD this cycle.
- oMD_DONE, out, 1, one-cycle pulse when the MD burst completes.
- oBANK, out, 1, frame-buffer bank currently displayed.
- oSWAP_ACK, out, 1, one-cycle pulse when oBANK toggles.
REQ-003 The block SHALL use one clock, iCLK, with asynchronous active-low reset iRST_n; all state SHALL be in iCLK flops.

Function
REQ-004 LCD SHALL have absolute priority: whenever iLCD_REQ=1, in the same cycle, oRD_EN=1, oRD_SEL=0 and oMD_VALID=0 (combinational path).
REQ-005 The FSM SHALL have four states: IDLE, GAP, XFER, HOLD. oMD_GNT=1 in GAP, XFER and HOLD.
REQ-006 IDLE, on iMD_REQ=1, iLCD_REQ=0 and iMD_LEN!=0:
- latch iMD_LEN into the remaining-word counter (rem);
- load the gap counter with GUARD;
- go to GAP.
REQ-007 IDLE, on iMD_REQ=1 with iMD_LEN=0: stay in IDLE, pulse oMD_DONE in the next cycle, perform no read.
REQ-008 GAP:
- decrement the gap counter on each cycle with iLCD_REQ=0;
- go to XFER after the counter reaches 0;
- any cycle with iLCD_REQ=1 goes to HOLD.
REQ-009 XFER, each cycle with iLCD_REQ=0:
- drive oRD_EN=1, oRD_SEL=1, oMD_VALID=1;
- decrement rem;
- on the read with rem=1, go to IDLE and pulse oMD_DONE in the next cycle.
REQ-010 XFER with iLCD_REQ=1: the MD read SHALL NOT occur, rem SHALL hold, and the FSM goes to HOLD.
REQ-011 HOLD: rem SHALL be held; on the first cycle with iLCD_REQ=0, reload the gap counter with GUARD and go to GAP.
REQ-012 Once latched, a burst SHALL run to completion; deasserting iMD_REQ mid-burst and changing iMD_LEN SHALL be ignored.
REQ-013 With iMD_REQ held high, a new burst MAY start no earlier than the cycle after oMD_DONE.
REQ-014 In IDLE with iLCD_REQ=0: oRD_EN=0 and oRD_SEL=0.
REQ-015 Exactly iMD_LEN oMD_VALID cycles SHALL occur per burst.
REQ-016 rem SHALL never underflow or wrap.
REQ-017 Bank swap:
- iSWAP_REQ SHALL set a pending flag.
- The iLCD_VD falling edge is registered iLCD_VD=1 in the previous cycle and iLCD_VD=0 now.
- On that edge with the flag set (or iSWAP_REQ=1 in the same cycle), oBANK SHALL toggle and oSWAP_ACK pulses for one cycle in the following cycle, and the flag clears.
REQ-018 Multiple iSWAP_REQ pulses before one VD edge SHALL produce one swap.
REQ-019 Swapping SHALL be independent of the FSM state.

Reset
REQ-020 On iRST_n=0, the block SHALL asynchronously set:
- FSM to IDLE; rem and the gap counter to 0;
- the swap flag to 0 and oBANK to 0;
- the iLCD_VD delay register to 1, so no false edge occurs after reset;
- oMD_GNT, oMD_VALID, oMD_DONE and oSWAP_ACK to 0.
REQ-021 While in reset, oRD_EN and oRD_SEL SHALL be 0 whenever iLCD_REQ=0.
REQ-022 Reset asserted mid-burst SHALL abort the burst with no oMD_DONE.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- iLCD_REQ=0 throughout, iMD_REQ=1, iMD_LEN=4, GUARD=2 -> oMD_GNT rises; 4 consecutive oMD_VALID cycles after 2 gap cycles; oMD_DONE pulses once.
- iMD_LEN=8; iLCD_REQ=1 for 5 cycles after 3 MD words -> 5 cycles oRD_SEL=0 with no oMD_VALID; HOLD, then a 2-cycle GAP; 5 remaining words; 8 oMD_VALID total.
- iMD_LEN=0 with iMD_REQ=1 -> oMD_DONE pulse, no oRD_EN, oMD_GNT stays 0.
- iSWAP_REQ twice, then an iLCD_VD 1->0 edge -> oBANK 0->1 and one oSWAP_ACK; a second VD edge with no request -> no toggle.
- iRST_n low during XFER with rem=3 -> all outputs 0, no oMD_DONE; after release the FSM is in IDLE with oBANK=0.
- iLCD_REQ toggling every cycle during GAP -> no MD read ever occurs while any iLCD_REQ=1 cycle lies within the last GUARD cycles.

Source files
------------

// File: rtl/sdram_rd_sched.sv
// rtl/sdram_rd_sched.sv - SDRAM read-port arbiter: LCD priority, guarded MD bursts, VD-aligned bank swap
module sdram_rd_sched #(
    parameter int GUARD = 2,
    parameter int LEN_W = 8
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic             iLCD_REQ,
    input  logic             iLCD_VD,
    input  logic             iMD_REQ,
    input  logic [LEN_W-1:0] iMD_LEN,
    input  logic             iSWAP_REQ,
    output logic             oRD_EN,
    output logic             oRD_SEL,
    output logic             oMD_GNT,
    output logic             oMD_VALID,
    output logic             oMD_DONE,
    output logic             oBANK,
    output logic             oSWAP_ACK
);

    localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
    localparam logic [GW-1:0] GUARD_C = GW'(GUARD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_XFER = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             done_q, done_d;
    logic             pend_q, pend_d;
    logic             bank_q, bank_d;
    logic             ack_q, ack_d;
    logic             vd_q, vd_d;
    logic             md_rd;
    logic             vd_fall;
    logic             swap_now;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
            bank_q  <= 1'b0;
            ack_q   <= 1'b0;
            vd_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
            bank_q  <= bank_d;
            ack_q   <= ack_d;
            vd_q    <= vd_d;
        end
    end

    // A new request is refused while done_q is high so back-to-back bursts
    // leave at least one cycle between the done pulse and the next latch.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        md_rd   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iMD_REQ && !done_q) begin
                    if (iMD_LEN == '0) begin
                        done_d = 1'b1;
                    end else if (!iLCD_REQ) begin
                        rem_d   = iMD_LEN;
                        gap_d   = GUARD_C;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (iLCD_REQ) begin
                    state_d = S_HOLD;
                end else if (gap_q <= GW'(1)) begin
                    gap_d   = '0;
                    state_d = S_XFER;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            S_XFER: begin
                if (iLCD_REQ) begin
                    state_d = S_HOLD;
                end else begin
                    if (rem_q != '0) begin
                        md_rd = 1'b1;
                        rem_d = rem_q - LEN_W'(1);
                    end
                    if (rem_q <= LEN_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = (rem_q == LEN_W'(1));
                    end
                end
            end
            S_HOLD: begin
                if (!iLCD_REQ) begin
                    gap_d   = GUARD_C;
                    state_d = S_GAP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bank swap runs beside the read FSM and only ever looks at VD and the request.
    always_comb begin
        vd_d     = iLCD_VD;
        vd_fall  = vd_q && !iLCD_VD;
        swap_now = vd_fall && (pend_q || iSWAP_REQ);
        bank_d   = bank_q ^ swap_now;
        ack_d    = swap_now;
        pend_d   = vd_fall ? 1'b0 : (pend_q || iSWAP_REQ);
    end

    assign oRD_EN    = iLCD_REQ || md_rd;
    assign oRD_SEL   = md_rd;
    assign oMD_VALID = md_rd;
    assign oMD_GNT   = (state_q != S_IDLE);
    assign oMD_DONE  = done_q;
    assign oBANK     = bank_q;
    assign oSWAP_ACK = ack_q;

endmodule

// File: tb/tb_sdram_rd_sched.sv
// tb/tb_sdram_rd_sched.sv - directed self-checking bench for sdram_rd_sched
module tb_sdram_rd_sched;

    logic       iCLK;
    logic       iRST_n;
    logic       iLCD_REQ;
    logic       iLCD_VD;
    logic       iMD_REQ;
    logic [7:0] iMD_LEN;
    logic       iSWAP_REQ;
    logic       oRD_EN;
    logic       oRD_SEL;
    logic       oMD_GNT;
    logic       oMD_VALID;
    logic       oMD_DONE;
    logic       oBANK;
    logic       oSWAP_ACK;

    int checks;
    int errors;

    sdram_rd_sched #(.GUARD(2), .LEN_W(8)) dut (
        .iCLK      (iCLK),
        .iRST_n    (iRST_n),
        .iLCD_REQ  (iLCD_REQ),
        .iLCD_VD   (iLCD_VD),
        .iMD_REQ   (iMD_REQ),
        .iMD_LEN   (iMD_LEN),
        .iSWAP_REQ (iSWAP_REQ),
        .oRD_EN    (oRD_EN),
        .oRD_SEL   (oRD_SEL),
        .oMD_GNT   (oMD_GNT),
        .oMD_VALID (oMD_VALID),
        .oMD_DONE  (oMD_DONE),
        .oBANK     (oBANK),
        .oSWAP_ACK (oSWAP_ACK)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Observation vector order: {rd_en, rd_sel, gnt, valid, done}
    task automatic next_cycle();
        @(posedge iCLK);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        #1;
        #3;
        obs = {oRD_EN, oRD_SEL, oMD_GNT, oMD_VALID, oMD_DONE, oBANK, oSWAP_ACK};
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want %b", obs, 7'b0);
        end
        iLCD_REQ = 1'b1;
        #1;
        checks++;
        if ({oRD_EN, oRD_SEL} !== 2'b10) begin
            errors++;
            $display("FAIL reset_lcd_comb got %b want %b", {oRD_EN, oRD_SEL}, 2'b10);
        end
        iLCD_REQ = 1'b0;
        next_cycle();
        iRST_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_burst4_back_to_back();
        logic [4:0] obs;
        logic [4:0] exp;
        logic v, g, d;
        int nvalid;
        nvalid = 0;
        for (int c = 0; c <= 16; c++) begin
            iMD_LEN = 8'd4;
            iMD_REQ = (c <= 8);
            #3;
            v = (c >= 3 && c <= 6) || (c >= 11 && c <= 14);
            g = (c >= 1 && c <= 6) || (c >= 9 && c <= 14);
            d = (c == 7) || (c == 15);
            exp = {v, v, g, v, d};
            obs = {oRD_EN, oRD_SEL, oMD_GNT, oMD_VALID, oMD_DONE};
            if (oMD_VALID === 1'b1) nvalid++;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL burst4 cyc %0d got %b want %b", c, obs, exp);
            end
            next_cycle();
        end
        iMD_REQ = 1'b0;
        checks++;
        if (nvalid != 8) begin
            errors++;
            $display("FAIL burst4_valid_count got %0d want 8", nvalid);
        end
    endtask

    task automatic test_lcd_preempt();
        logic [4:0] obs;
        logic [4:0] exp;
        logic v, g, d, lcd;
        int nvalid;
        nvalid = 0;
        for (int c = 0; c <= 20; c++) begin
            lcd      = (c >= 6 && c <= 10);
            iLCD_REQ = lcd;
            iMD_REQ  = (c == 0);
            iMD_LEN  = (c == 0) ? 8'd8 : 8'd3;
            #3;
            v = (c >= 3 && c <= 5) || (c >= 14 && c <= 18);
            g = (c >= 1 && c <= 18);
            d = (c == 19);
            exp = {lcd | v, v, g, v, d};
            obs = {oRD_EN, oRD_SEL, oMD_GNT, oMD_VALID, oMD_DONE};
            if (oMD_VALID === 1'b1) nvalid++;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL preempt cyc %0d got %b want %b", c, obs, exp);
            end
            next_cycle();
        end
        iLCD_REQ = 1'b0;
        checks++;
        if (nvalid != 8) begin
            errors++;
            $display("FAIL preempt_valid_count got %0d want 8", nvalid);
        end
    endtask

    task automatic test_zero_len();
        logic [4:0] obs;
        logic [4:0] exp;
        for (int c = 0; c <= 2; c++) begin
            iMD_REQ = (c == 0);
            iMD_LEN = 8'd0;
            #3;
            exp = {4'b0000, (c == 1)};
            obs = {oRD_EN, oRD_SEL, oMD_GNT, oMD_VALID, oMD_DONE};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL zero_len cyc %0d got %b want %b", c, obs, exp);
            end
            next_cycle();
        end
    endtask

    task automatic test_swap();
        logic [1:0] obs;
        logic [1:0] exp;
        for (int c = 0; c <= 10; c++) begin
            iSWAP_REQ = (c == 0) || (c == 2);
            iLCD_VD   = !((c == 5) || (c == 6) || (c == 9) || (c == 10));
            #3;
            exp = {(c >= 6), (c == 6)};
            obs = {oBANK, oSWAP_ACK};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL swap cyc %0d got %b want %b", c, obs, exp);
            end
            next_cycle();
        end
        iSWAP_REQ = 1'b0;
        iLCD_VD   = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        logic [4:0] obs;
        logic [4:0] exp;
        logic v, g;
        for (int c = 0; c <= 12; c++) begin
            iMD_REQ = (c == 0);
            iMD_LEN = 8'd6;
            if (c == 6) iRST_n = 1'b0;
            if (c == 9) iRST_n = 1'b1;
            #3;
            v = (c >= 3 && c <= 5);
            g = (c >= 1 && c <= 5);
            exp = {v, v, g, v, 1'b0};
            obs = {oRD_EN, oRD_SEL, oMD_GNT, oMD_VALID, oMD_DONE};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid cyc %0d got %b want %b", c, obs, exp);
            end
            if (c >= 6) begin
                checks++;
                if ({oBANK, oSWAP_ACK} !== 2'b00) begin
                    errors++;
                    $display("FAIL reset_mid_bank cyc %0d got %b want 00", c, {oBANK, oSWAP_ACK});
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_swap_same_cycle();
        logic [1:0] obs;
        logic [1:0] exp;
        for (int c = 0; c <= 3; c++) begin
            iSWAP_REQ = (c == 1);
            iLCD_VD   = (c != 1);
            #3;
            exp = {(c >= 2), (c == 2)};
            obs = {oBANK, oSWAP_ACK};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL swap_same cyc %0d got %b want %b", c, obs, exp);
            end
            next_cycle();
        end
        iSWAP_REQ = 1'b0;
        iLCD_VD   = 1'b1;
    endtask

    task automatic test_gap_toggle();
        logic [4:0] obs;
        logic [4:0] exp;
        logic v, g, d, lcd;
        for (int c = 0; c <= 27; c++) begin
            lcd      = (c >= 2 && c <= 20 && (c % 2 == 0));
            iLCD_REQ = lcd;
            iMD_REQ  = (c == 0);
            iMD_LEN  = 8'd2;
            #3;
            v = (c == 24) || (c == 25);
            g = (c >= 1 && c <= 25);
            d = (c == 26);
            exp = {lcd | v, v, g, v, d};
            obs = {oRD_EN, oRD_SEL, oMD_GNT, oMD_VALID, oMD_DONE};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL gap_toggle cyc %0d got %b want %b", c, obs, exp);
            end
            next_cycle();
        end
        iLCD_REQ = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        iRST_n    = 1'b0;
        iLCD_REQ  = 1'b0;
        iLCD_VD   = 1'b1;
        iMD_REQ   = 1'b0;
        iMD_LEN   = 8'd0;
        iSWAP_REQ = 1'b0;
        test_reset();
        test_burst4_back_to_back();
        test_lcd_preempt();
        test_zero_len();
        test_swap();
        test_reset_mid_burst();
        test_swap_same_cycle();
        test_gap_toggle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
